edge_detect_multi: RTL and testbench

//  Parametrised multi-channel edge detector for board-level status/strap/button inputs.
//  Per channel: synchronise the asynchronous input, debounce it, and report a filtered

---
 rtl/edge_detect_pkg.sv | 21 ++
 rtl/edge_filter_ch.sv | 81 ++++++++
 rtl/edge_detect_multi.sv | 67 ++++++
 tb/tb_edge_detect_multi.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/edge_detect_pkg.sv
// Shared constants, counter-width helper and per-channel filter state for edge_detect_multi.
package edge_detect_pkg;

    localparam int unsigned SYNC_STAGES_MIN = 2;
    localparam int unsigned DEB_CYCLES_MIN  = 1;
    localparam int unsigned CH_MIN          = 1;

    // Storage width of the debounce counter field; only cnt_width(DEB_CYCLES) bits ever toggle.
    localparam int unsigned CNT_W_MAX = 16;

    // Bits needed to count 0..deb_cycles.
    function automatic int unsigned cnt_width(input int unsigned deb_cycles);
        return (deb_cycles < 1) ? 1 : $clog2(deb_cycles + 1);
    endfunction

    typedef struct packed {
        logic                 level;
        logic [CNT_W_MAX-1:0] cnt;
    } ch_state_t;

endpackage

// File: rtl/edge_filter_ch.sv
// One channel: synchroniser chain, debounce counter, registered rising/falling/any pulses.
module edge_filter_ch
    import edge_detect_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DEB_CYCLES  = 4,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_signal,
    input  logic i_en,
    output logic o_level,
    output logic o_pos,
    output logic o_neg,
    output logic o_any
);

    localparam int unsigned          CNT_W    = cnt_width(DEB_CYCLES);
    localparam logic [CNT_W_MAX-1:0] CNT_LAST = CNT_W_MAX'(DEB_CYCLES - 1);

    if (CNT_W > CNT_W_MAX) begin : g_cnt_w_chk
        $error("edge_filter_ch: DEB_CYCLES too large for the counter field");
    end

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    ch_state_t              state_q;
    ch_state_t              state_d;
    logic                   accept_c;

    // Synchroniser; the reset value matches the filtered level so reset release is silent.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_signal};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Debounce: a new level is accepted after DEB_CYCLES consecutive differing samples.
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        if (s == state_q.level) begin
            state_d.cnt = '0;
        end else if (state_q.cnt == CNT_LAST) begin
            state_d.level = s;
            state_d.cnt   = '0;
            accept_c      = 1'b1;
        end else begin
            state_d.cnt = state_q.cnt + CNT_W_MAX'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= '{level: RST_VAL, cnt: '0};
        end else begin
            state_q <= state_d;
        end
    end

    // Pulses land in the same cycle as the level update; the enable only masks them.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pos <= 1'b0;
            o_neg <= 1'b0;
            o_any <= 1'b0;
        end else begin
            o_pos <= i_en & accept_c & s;
            o_neg <= i_en & accept_c & ~s;
            o_any <= i_en & accept_c;
        end
    end

    assign o_level = state_q.level;

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel synchronised/debounced edge detector.
// Define EDGE_DETECT_STICKY_EN to add i_clr and the latched o_pos_sticky/o_neg_sticky outputs.
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int unsigned    CH          = 8,
    parameter int unsigned    SYNC_STAGES = 2,
    parameter int unsigned    DEB_CYCLES  = 4,
    parameter logic [CH-1:0]  RST_VAL     = '0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [CH-1:0] i_signal,
    input  logic [CH-1:0] i_en,
    output logic [CH-1:0] o_level,
    output logic [CH-1:0] o_pos,
    output logic [CH-1:0] o_neg,
    output logic [CH-1:0] o_any
`ifdef EDGE_DETECT_STICKY_EN
    ,
    input  logic [CH-1:0] i_clr,
    output logic [CH-1:0] o_pos_sticky,
    output logic [CH-1:0] o_neg_sticky
`endif
);

    if (CH < CH_MIN) begin : g_ch_chk
        $error("edge_detect_multi: CH must be >= 1");
    end
    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_sync_chk
        $error("edge_detect_multi: SYNC_STAGES must be >= 2");
    end
    if (DEB_CYCLES < DEB_CYCLES_MIN) begin : g_deb_chk
        $error("edge_detect_multi: DEB_CYCLES must be >= 1");
    end

    for (genvar i = 0; i < int'(CH); i++) begin : g_ch
        edge_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYCLES  (DEB_CYCLES),
            .RST_VAL     (RST_VAL[i])
        ) u_ch (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_signal (i_signal[i]),
            .i_en     (i_en[i]),
            .o_level  (o_level[i]),
            .o_pos    (o_pos[i]),
            .o_neg    (o_neg[i]),
            .o_any    (o_any[i])
        );
    end

`ifdef EDGE_DETECT_STICKY_EN
    // Sticky event flags; a same-cycle pulse wins over the clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pos_sticky <= '0;
            o_neg_sticky <= '0;
        end else begin
            o_pos_sticky <= (o_pos_sticky & ~i_clr) | o_pos;
            o_neg_sticky <= (o_neg_sticky & ~i_clr) | o_neg;
        end
    end
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
// Directed bench for edge_detect_multi: per-cycle vector table plus hand-written corner sequences.
module tb_edge_detect_multi;

    logic       clk = 1'b0;
    logic       rst_a_n, rst_b_n;
    logic [7:0] sig_a, sig_b, en_a, en_b;
    logic [7:0] level_a, pos_a, neg_a, any_a;
    logic [7:0] level_b, pos_b, neg_b, any_b;
`ifdef EDGE_DETECT_STICKY_EN
    logic [7:0] clr_a, clr_b, pst_a, nst_a, pst_b, nst_b;
`endif

    always #5 clk = ~clk;

    edge_detect_multi #(.CH(8), .SYNC_STAGES(2), .DEB_CYCLES(4), .RST_VAL(8'h00)) u_dut_a (
        .i_clk        (clk),
        .i_rst_n      (rst_a_n),
        .i_signal     (sig_a),
        .i_en         (en_a),
        .o_level      (level_a),
        .o_pos        (pos_a),
        .o_neg        (neg_a),
        .o_any        (any_a)
`ifdef EDGE_DETECT_STICKY_EN
        ,
        .i_clr        (clr_a),
        .o_pos_sticky (pst_a),
        .o_neg_sticky (nst_a)
`endif
    );

    edge_detect_multi #(.CH(8), .SYNC_STAGES(2), .DEB_CYCLES(4), .RST_VAL(8'hFF)) u_dut_b (
        .i_clk        (clk),
        .i_rst_n      (rst_b_n),
        .i_signal     (sig_b),
        .i_en         (en_b),
        .o_level      (level_b),
        .o_pos        (pos_b),
        .o_neg        (neg_b),
        .o_any        (any_b)
`ifdef EDGE_DETECT_STICKY_EN
        ,
        .i_clr        (clr_b),
        .o_pos_sticky (pst_b),
        .o_neg_sticky (nst_b)
`endif
    );

    typedef struct {
        logic [7:0] sig;
        logic [7:0] en;
        logic [7:0] lvl;
        logic [7:0] pos;
        logic [7:0] neg;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void add_n(input int n, input logic [7:0] sig, input logic [7:0] en,
                                  input logic [7:0] lvl, input logic [7:0] pos,
                                  input logic [7:0] neg);
        vec_t v;
        v.sig = sig; v.en = en; v.lvl = lvl; v.pos = pos; v.neg = neg;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_a_n = 1'b0; rst_b_n = 1'b0;
        sig_a = 8'h00; sig_b = 8'h00; en_a = 8'hFF; en_b = 8'hFF;
`ifdef EDGE_DETECT_STICKY_EN
        clr_a = 8'h00; clr_b = 8'h00;
`endif
        repeat (3) step();
        chk("rst_a_level", level_a, 8'h00);
        chk("rst_a_pos",   pos_a,   8'h00);
        chk("rst_a_neg",   neg_a,   8'h00);
        chk("rst_a_any",   any_a,   8'h00);
        chk("rst_b_level", level_b, 8'hFF);
        chk("rst_b_neg",   neg_b,   8'h00);

        // Reset release with quiet inputs.
        add_n(20, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00);
        // ch0 clean rising step: accepted on the 6th edge, single-cycle pulse.
        add_n(5,  8'h01, 8'hFF, 8'h00, 8'h00, 8'h00);
        add_n(1,  8'h01, 8'hFF, 8'h01, 8'h01, 8'h00);
        add_n(2,  8'h01, 8'hFF, 8'h01, 8'h00, 8'h00);
        // ch1 3-cycle glitch is dropped.
        add_n(3,  8'h03, 8'hFF, 8'h01, 8'h00, 8'h00);
        add_n(6,  8'h01, 8'hFF, 8'h01, 8'h00, 8'h00);
        // ch1 4-cycle pulse: rise accepted, fall accepted 4 cycles later.
        add_n(4,  8'h03, 8'hFF, 8'h01, 8'h00, 8'h00);
        add_n(1,  8'h01, 8'hFF, 8'h01, 8'h00, 8'h00);
        add_n(1,  8'h01, 8'hFF, 8'h03, 8'h02, 8'h00);
        add_n(3,  8'h01, 8'hFF, 8'h03, 8'h00, 8'h00);
        add_n(1,  8'h01, 8'hFF, 8'h01, 8'h00, 8'h02);
        add_n(2,  8'h01, 8'hFF, 8'h01, 8'h00, 8'h00);
        // ch2 rising while disabled: level tracks, no pulse, none on re-enable.
        add_n(5,  8'h05, 8'hFB, 8'h01, 8'h00, 8'h00);
        add_n(1,  8'h05, 8'hFB, 8'h05, 8'h00, 8'h00);
        add_n(2,  8'h05, 8'hFB, 8'h05, 8'h00, 8'h00);
        add_n(3,  8'h05, 8'hFF, 8'h05, 8'h00, 8'h00);
        // ch2 falling once re-enabled.
        add_n(5,  8'h01, 8'hFF, 8'h05, 8'h00, 8'h00);
        add_n(1,  8'h01, 8'hFF, 8'h01, 8'h00, 8'h04);
        add_n(1,  8'h01, 8'hFF, 8'h01, 8'h00, 8'h00);

        rst_a_n = 1'b1;
        foreach (vecs[i]) begin
            sig_a = vecs[i].sig;
            en_a  = vecs[i].en;
            step();
            chk($sformatf("vec%0d_level", i), level_a, vecs[i].lvl);
            chk($sformatf("vec%0d_pos", i),   pos_a,   vecs[i].pos);
            chk($sformatf("vec%0d_neg", i),   neg_a,   vecs[i].neg);
            chk($sformatf("vec%0d_any", i),   any_a,   vecs[i].pos | vecs[i].neg);
        end
        en_a = 8'hFF;

        // RST_VAL=FF with inputs low: falling pulse on every channel at edge 6.
        rst_b_n = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("b_e%0d_level", k), level_b, (k < 6) ? 8'hFF : 8'h00);
            chk($sformatf("b_e%0d_neg", k),   neg_b,   (k == 6) ? 8'hFF : 8'h00);
            chk($sformatf("b_e%0d_pos", k),   pos_b,   8'h00);
            chk($sformatf("b_e%0d_any", k),   any_b,   (k == 6) ? 8'hFF : 8'h00);
`ifdef EDGE_DETECT_STICKY_EN
            chk($sformatf("b_e%0d_nst", k),   nst_b,   (k >= 7) ? 8'hFF : 8'h00);
            chk($sformatf("b_e%0d_pst", k),   pst_b,   8'h00);
`endif
        end

        // Return all of dut A to low.
        sig_a = 8'h00;
        repeat (8) step();
        chk("a_all_low", level_a, 8'h00);

        // ch3 rising; clear raised during the pulse cycle must not win.
        sig_a = 8'h08;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("s_e%0d_pos", k), pos_a, (k == 6) ? 8'h08 : 8'h00);
        end
`ifdef EDGE_DETECT_STICKY_EN
        chk("st_before", pst_a, 8'h00);
        clr_a = 8'h08;
`endif
        step();
        chk("s_pulse_gone", pos_a, 8'h00);
`ifdef EDGE_DETECT_STICKY_EN
        chk("st_set_wins", pst_a, 8'h08);
        clr_a = 8'h00;
`endif
        step();
`ifdef EDGE_DETECT_STICKY_EN
        chk("st_held", pst_a, 8'h08);
        chk("st_neg_idle", nst_a, 8'h00);
        clr_a = 8'h08;
`endif
        step();
`ifdef EDGE_DETECT_STICKY_EN
        chk("st_cleared", pst_a, 8'h00);
        clr_a = 8'h00;
`endif

        // Reset in the middle of a ch3 count (cnt=2 after four edges).
        sig_a = 8'h00;
        repeat (8) step();
        chk("m_low", level_a, 8'h00);
        sig_a = 8'h08;
        repeat (4) step();
        chk("m_counting", level_a, 8'h00);
        rst_a_n = 1'b0;
        #1;
        chk("m_rst_level", level_a, 8'h00);
        chk("m_rst_pos",   pos_a,   8'h00);
        step();
        rst_a_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk($sformatf("m_e%0d_level", k), level_a, (k == 6) ? 8'h08 : 8'h00);
            chk($sformatf("m_e%0d_pos", k),   pos_a,   (k == 6) ? 8'h08 : 8'h00);
`ifdef EDGE_DETECT_STICKY_EN
            chk($sformatf("m_e%0d_pst", k),   pst_a,   8'h00);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
